// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the MEM-stage controller (master) and the data memory (slave).
// Valid/ready request channel plus a single-cycle response pulse.
interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic              dmem_req_we;
  logic [ADDR_W-1:0] dmem_req_addr;
  logic [31:0]       dmem_req_wdata;
  logic [3:0]        dmem_req_be;
  logic              dmem_rsp_valid;
  logic [31:0]       dmem_rsp_rdata;

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues one data-memory access per load/store, stalls upstream while
// it is outstanding, and hands a registered, extended writeback value to MEM/WB.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ex_valid,
  input  logic [6:0]          ex_opcode,
  input  logic [31:0]         ex_instruction,
  input  logic [31:0]         ex_alu_result,
  input  logic [31:0]         ex_b_val,
  input  logic [4:0]          ex_rd,
  output logic                stall_out,
  mem_stage_ctrl_if.master    dmem,
  output logic                wb_valid,
  output logic [31:0]         wb_value,
  output logic [4:0]          wb_rd,
  output logic                wb_regwrite,
  output logic                misaligned,
  output logic                bus_error
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int         CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  // Abort once TIMEOUT_CYCLES-1 cycles have been spent in REQ+WAIT (counter starts at 0).
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            state_q;
  logic              req_valid_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [4:0]        rd_q;
  logic [CNT_W-1:0]  tmo_q;
  logic              wb_valid_q, wb_regwrite_q, misaligned_q, bus_error_q;
  logic [31:0]       wb_value_q;
  logic [4:0]        wb_rd_q;

  logic [2:0]  f3;
  logic        is_ld, is_st, is_mem, legal, algn, accept, tmo_last;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, rsh, ld_val;
  logic        unused_instr;

  assign unused_instr = ^{ex_instruction[31:15], ex_instruction[11:0]};

  always_comb begin
    f3     = ex_instruction[14:12];
    is_ld  = (ex_opcode == OP_LOAD);
    is_st  = (ex_opcode == OP_STORE);
    is_mem = is_ld | is_st;
    legal  = 1'b0;
    case (f3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = is_ld;
      default:                legal = 1'b0;
    endcase
    algn = 1'b0;
    case (f3[1:0])
      2'b00:   algn = 1'b1;
      2'b01:   algn = ~ex_alu_result[0];
      2'b10:   algn = (ex_alu_result[1:0] == 2'b00);
      default: algn = 1'b0;
    endcase
    accept = reset && (state_q == S_IDLE) && ex_valid && is_mem && legal && algn;
    be_d    = 4'b1111;
    wdata_d = ex_b_val;
    case (f3[1:0])
      2'b00: begin be_d = 4'b0001 << ex_alu_result[1:0]; wdata_d = {4{ex_b_val[7:0]}};  end
      2'b01: begin be_d = 4'b0011 << ex_alu_result[1:0]; wdata_d = {2{ex_b_val[15:0]}}; end
      default: ;
    endcase
  end

  // Load lane select: shift the addressed byte/half down to bit 0, then extend.
  always_comb begin
    rsh    = dmem.dmem_rsp_rdata >> {off_q, 3'b000};
    ld_val = dmem.dmem_rsp_rdata;
    case (f3_q)
      3'b000:  ld_val = {{24{rsh[7]}}, rsh[7:0]};
      3'b001:  ld_val = {{16{rsh[15]}}, rsh[15:0]};
      3'b100:  ld_val = {24'h0, rsh[7:0]};
      3'b101:  ld_val = {16'h0, rsh[15:0]};
      default: ld_val = dmem.dmem_rsp_rdata;
    endcase
  end

  assign tmo_last  = (tmo_q == TMO_LAST);
  assign stall_out = accept || (state_q != S_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      req_valid_q   <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      f3_q          <= '0;
      off_q         <= '0;
      rd_q          <= '0;
      tmo_q         <= '0;
      wb_valid_q    <= 1'b0;
      wb_value_q    <= '0;
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
      misaligned_q  <= 1'b0;
      bus_error_q   <= 1'b0;
    end else begin
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      misaligned_q  <= 1'b0;
      bus_error_q   <= 1'b0;
      case (state_q)
        S_IDLE: if (ex_valid) begin
          if (accept) begin
            state_q     <= S_REQ;
            req_valid_q <= 1'b1;
            we_q        <= is_st;
            addr_q      <= {ex_alu_result[ADDR_W-1:2], 2'b00};
            off_q       <= ex_alu_result[1:0];
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            f3_q        <= f3;
            rd_q        <= ex_rd;
            tmo_q       <= '0;
          end else begin
            // Non-memory pass-through, or a rejected (misaligned/reserved) access.
            wb_valid_q    <= 1'b1;
            wb_value_q    <= ex_alu_result;
            wb_rd_q       <= ex_rd;
            wb_regwrite_q <= !is_mem && (ex_rd != 5'd0);
            misaligned_q  <= is_mem;
          end
        end
        S_REQ: begin
          tmo_q <= tmo_q + 1'b1;
          if (tmo_last) begin
            state_q     <= S_IDLE;
            req_valid_q <= 1'b0;
            wb_valid_q  <= 1'b1;
            bus_error_q <= 1'b1;
            wb_value_q  <= '0;
            wb_rd_q     <= rd_q;
          end else if (dmem.dmem_req_ready) begin
            state_q     <= S_WAIT;
            req_valid_q <= 1'b0;
          end
        end
        S_WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          // A response coincident with the timeout completes normally.
          if (dmem.dmem_rsp_valid) begin
            state_q       <= S_IDLE;
            wb_valid_q    <= 1'b1;
            wb_rd_q       <= rd_q;
            wb_value_q    <= we_q ? 32'h0 : ld_val;
            wb_regwrite_q <= !we_q && (rd_q != 5'd0);
          end else if (tmo_last) begin
            state_q     <= S_IDLE;
            wb_valid_q  <= 1'b1;
            bus_error_q <= 1'b1;
            wb_value_q  <= '0;
            wb_rd_q     <= rd_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dmem.dmem_req_valid = req_valid_q;
  assign dmem.dmem_req_we    = we_q;
  assign dmem.dmem_req_addr  = addr_q;
  assign dmem.dmem_req_wdata = wdata_q;
  assign dmem.dmem_req_be    = be_q;

  assign wb_valid    = wb_valid_q;
  assign wb_value    = wb_value_q;
  assign wb_rd       = wb_rd_q;
  assign wb_regwrite = wb_regwrite_q;
  assign misaligned  = misaligned_q;
  assign bus_error   = bus_error_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed plan cases plus randomized loads/stores
// checked against an arithmetic reference model of the access rules.
module tb_mem_stage_ctrl;
  localparam int TMO = 8;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic        clock = 1'b0, reset = 1'b0;
  logic        ex_valid = 1'b0;
  logic [6:0]  ex_opcode = '0;
  logic [31:0] ex_instruction = '0, ex_alu_result = '0, ex_b_val = '0;
  logic [4:0]  ex_rd = '0;
  logic        stall_out, wb_valid, wb_regwrite, misaligned, bus_error;
  logic [31:0] wb_value;
  logic [4:0]  wb_rd;
  int checks = 0, failures = 0;

  mem_stage_ctrl_if #(.ADDR_W(32)) dmem_if ();

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_instruction(ex_instruction), .ex_alu_result(ex_alu_result), .ex_b_val(ex_b_val),
    .ex_rd(ex_rd), .stall_out(stall_out), .dmem(dmem_if), .wb_valid(wb_valid),
    .wb_value(wb_value), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .misaligned(misaligned), .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit got; int stalls; int nreq; bit stall_acc; bit stall_wb; bit unstable;
    logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata;
    logic [31:0] wb_value; logic [4:0] wb_rd; logic wb_regwrite, misaligned, bus_error;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic int size_of(logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit model_ok(bit is_ld, logic [2:0] f3, logic [31:0] addr);
    bit legal;
    legal = is_ld ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
    return legal && (addr % size_of(f3) == 0);
  endfunction

  function automatic logic [31:0] ld_model(logic [2:0] f3, logic [31:0] addr, logic [31:0] rd);
    int unsigned b, h, off;
    off = addr % 4;
    b = (rd >> (8 * off)) % 256;
    h = (rd >> (8 * off)) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] be_model(logic [2:0] f3, logic [31:0] addr);
    logic [3:0] be;
    for (int i = 0; i < 4; i++) be[i] = (i >= addr % 4) && (i < addr % 4 + size_of(f3));
    return be;
  endfunction

  function automatic logic [31:0] wd_model(logic [2:0] f3, logic [31:0] bval);
    logic [31:0] wd;
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = 8'((bval >> (8 * (i % size_of(f3)))) % 256);
    return wd;
  endfunction

  // ---------------- stimulus driver (observes only; callers compare) ----------------
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] bval, input logic [4:0] rd, input int rdy_dly,
                        input int rsp_dly, input bit spur, input logic [31:0] rdata,
                        output obs_t o);
    int acc;
    o = '{default: 0};
    acc = -1;
    ex_valid = 1'b1; ex_opcode = op; ex_alu_result = addr; ex_b_val = bval; ex_rd = rd;
    ex_instruction = {17'($urandom), f3, 12'($urandom)};
    for (int k = 0; k < 60 && !o.got; k++) begin
      dmem_if.dmem_req_ready = (o.nreq >= rdy_dly);
      dmem_if.dmem_rsp_valid = (acc >= 0) ? (k - acc == rsp_dly) : spur;
      dmem_if.dmem_rsp_rdata = (acc >= 0 && k - acc == rsp_dly) ? rdata : $urandom;
      #1;
      if (k == 0) o.stall_acc = stall_out;
      if (stall_out) o.stalls++;
      if (dmem_if.dmem_req_valid) begin
        if (o.nreq == 0) begin
          o.addr = dmem_if.dmem_req_addr; o.we = dmem_if.dmem_req_we;
          o.be = dmem_if.dmem_req_be; o.wdata = dmem_if.dmem_req_wdata;
        end else if ({dmem_if.dmem_req_addr, dmem_if.dmem_req_we, dmem_if.dmem_req_be,
                      dmem_if.dmem_req_wdata} !== {o.addr, o.we, o.be, o.wdata})
          o.unstable = 1;
        if (dmem_if.dmem_req_ready && acc < 0) acc = k;
        o.nreq++;
      end
      @(posedge clock); #1;
      if (wb_valid) begin
        o.got = 1; o.wb_value = wb_value; o.wb_rd = wb_rd; o.wb_regwrite = wb_regwrite;
        o.misaligned = misaligned; o.bus_error = bus_error;
      end
    end
    ex_valid = 1'b0; dmem_if.dmem_req_ready = 1'b0; dmem_if.dmem_rsp_valid = 1'b0;
    #1 o.stall_wb = stall_out;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    dmem_if.dmem_req_ready = 1'b0; dmem_if.dmem_rsp_valid = 1'b0; dmem_if.dmem_rsp_rdata = '0;
    reset = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    ex_valid = 1'b1; ex_opcode = OP_LOAD; ex_instruction = 32'h0000_2000; ex_alu_result = 32'h40;
    #1;
    checks++;
    if ({stall_out, dmem_if.dmem_req_valid, wb_valid, wb_value, wb_rd, wb_regwrite, misaligned,
         bus_error, dmem_if.dmem_req_addr, dmem_if.dmem_req_be} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: stall=%b req_valid=%b wb_valid=%b wb_value=%h expected all 0",
               stall_out, dmem_if.dmem_req_valid, wb_valid, wb_value);
    end
    ex_valid = 1'b0;
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_alu();
    obs_t o;
    logic [6:0] op;
    logic [31:0] v;
    logic [4:0] rd;
    run_op(7'b0110011, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 0, 1, 0, 32'h0, o);
    checks++;
    if ({o.got, o.wb_value, o.wb_rd, o.wb_regwrite, o.misaligned, o.stalls, o.nreq} !==
        {1'b1, 32'h1234, 5'd5, 1'b1, 1'b0, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL alu_add: got=%b value=%h rd=%0d rw=%b stalls=%0d reqs=%0d want 1/1234/5/1/0/0",
               o.got, o.wb_value, o.wb_rd, o.wb_regwrite, o.stalls, o.nreq);
    end
    for (int n = 0; n < 10; n++) begin
      do op = 7'($urandom); while (op == OP_LOAD || op == OP_STORE);
      v = $urandom; rd = (n % 4 == 0) ? 5'd0 : 5'($urandom);
      run_op(op, 3'($urandom), v, $urandom, rd, 0, 1, 0, 32'h0, o);
      checks++;
      if ({o.got, o.wb_value, o.wb_rd, o.wb_regwrite, o.misaligned, o.stalls, o.nreq} !==
          {1'b1, v, rd, rd != 0, 1'b0, 32'd0, 32'd0}) begin
        failures++;
        $display("FAIL alu_rand op=%h: value=%h rd=%0d rw=%b stalls=%0d want value=%h rd=%0d rw=%b",
                 op, o.wb_value, o.wb_rd, o.wb_regwrite, o.stalls, v, rd, rd != 0);
      end
    end
  endtask

  task automatic test_load();
    obs_t o;
    logic [2:0] f3;
    logic [31:0] a, rdat, exp;
    logic [4:0] rd;
    int rdy, rsp;
    run_op(OP_LOAD, 3'b000, 32'h103, 32'h0, 5'd7, 0, 1, 0, 32'h80FF_0000, o);
    checks++;
    if ({o.got, o.wb_value, o.wb_regwrite, o.addr, o.we, o.stalls, o.stall_wb} !==
        {1'b1, 32'hFFFF_FF80, 1'b1, 32'h100, 1'b0, 32'd3, 1'b0}) begin
      failures++;
      $display("FAIL lb_sign: value=%h addr=%h stalls=%0d stall_wb=%b want ffffff80/100/3/0",
               o.wb_value, o.addr, o.stalls, o.stall_wb);
    end
    run_op(OP_LOAD, 3'b100, 32'h103, 32'h0, 5'd7, 0, 1, 0, 32'h80FF_0000, o);
    checks++;
    if ({o.got, o.wb_value, o.addr, o.stalls} !== {1'b1, 32'h0000_0080, 32'h100, 32'd3}) begin
      failures++;
      $display("FAIL lbu_zero: value=%h addr=%h stalls=%0d want 00000080/100/3",
               o.wb_value, o.addr, o.stalls);
    end
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(4)) 0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5; endcase
      a = $urandom; a = a - (a % size_of(f3));
      rdat = $urandom; rd = (n % 5 == 0) ? 5'd0 : 5'($urandom);
      rdy = $urandom_range(2); rsp = $urandom_range(1, 3);
      exp = ld_model(f3, a, rdat);
      run_op(OP_LOAD, f3, a, $urandom, rd, rdy, rsp, n % 3 == 0, rdat, o);
      checks++;
      if ({o.got, o.wb_value, o.wb_rd, o.wb_regwrite, o.addr, o.we, o.unstable, o.nreq, o.stalls,
           o.bus_error, o.misaligned} !==
          {1'b1, exp, rd, rd != 0, a - (a % 4), 1'b0, 1'b0, rdy + 1, 1 + rdy + 1 + rsp, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL load_rand f3=%0d addr=%h rdata=%h: value=%h rw=%b req_addr=%h reqs=%0d stalls=%0d want value=%h reqs=%0d stalls=%0d",
                 f3, a, rdat, o.wb_value, o.wb_regwrite, o.addr, o.nreq, o.stalls, exp, rdy + 1, rdy + rsp + 2);
      end
    end
  endtask

  task automatic test_store();
    obs_t o;
    logic [2:0] f3;
    logic [31:0] a, b;
    run_op(OP_STORE, 3'b001, 32'h202, 32'h0000_BEEF, 5'd9, 0, 1, 0, 32'h0, o);
    checks++;
    if ({o.got, o.we, o.be, o.wdata, o.addr, o.wb_regwrite, o.stalls} !==
        {1'b1, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h200, 1'b0, 32'd3}) begin
      failures++;
      $display("FAIL sh_lanes: we=%b be=%b wdata=%h addr=%h rw=%b stalls=%0d want 1/1100/beefbeef/200/0/3",
               o.we, o.be, o.wdata, o.addr, o.wb_regwrite, o.stalls);
    end
    for (int n = 0; n < 15; n++) begin
      f3 = 3'($urandom_range(2));
      a = $urandom; a = a - (a % size_of(f3)); b = $urandom;
      run_op(OP_STORE, f3, a, b, 5'($urandom_range(1, 31)), $urandom_range(2), $urandom_range(1, 3), 0, $urandom, o);
      checks++;
      if ({o.got, o.we, o.be, o.wdata, o.addr, o.unstable, o.wb_regwrite, o.bus_error} !==
          {1'b1, 1'b1, be_model(f3, a), wd_model(f3, b), a - (a % 4), 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL store_rand f3=%0d addr=%h b=%h: be=%b wdata=%h rw=%b want be=%b wdata=%h",
                 f3, a, b, o.be, o.wdata, o.wb_regwrite, be_model(f3, a), wd_model(f3, b));
      end
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    bit ld;
    logic [2:0] f3;
    logic [31:0] a;
    logic [4:0] rd;
    run_op(OP_LOAD, 3'b010, 32'h101, 32'h0, 5'd3, 0, 1, 0, 32'h0, o);
    checks++;
    if ({o.got, o.misaligned, o.wb_regwrite, o.wb_value, o.nreq, o.stalls, o.bus_error} !==
        {1'b1, 1'b1, 1'b0, 32'h101, 32'd0, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL lw_misaligned: got=%b mis=%b rw=%b value=%h reqs=%0d stalls=%0d want 1/1/0/101/0/0",
               o.got, o.misaligned, o.wb_regwrite, o.wb_value, o.nreq, o.stalls);
    end
    for (int n = 0; n < 10; n++) begin
      do begin ld = $urandom_range(1); f3 = 3'($urandom); a = $urandom; end
      while (model_ok(ld, f3, a));
      rd = 5'($urandom_range(1, 31));
      run_op(ld ? OP_LOAD : OP_STORE, f3, a, $urandom, rd, 0, 1, 0, $urandom, o);
      checks++;
      if ({o.got, o.misaligned, o.wb_regwrite, o.wb_value, o.wb_rd, o.nreq, o.stall_acc} !==
          {1'b1, 1'b1, 1'b0, a, rd, 32'd0, 1'b0}) begin
        failures++;
        $display("FAIL misaligned_rand ld=%b f3=%0d addr=%h: mis=%b rw=%b reqs=%0d stall=%b want 1/0/0/0",
                 ld, f3, a, o.misaligned, o.wb_regwrite, o.nreq, o.stall_acc);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_op(OP_LOAD, 3'b010, 32'h400, 32'h0, 5'd4, 1000, 1, 0, 32'h0, o);
    checks++;
    if ({o.got, o.bus_error, o.wb_regwrite, o.nreq, o.unstable, o.addr, o.stalls, o.stall_wb} !==
        {1'b1, 1'b1, 1'b0, TMO - 1, 1'b0, 32'h400, TMO, 1'b0}) begin
      failures++;
      $display("FAIL timeout_req: got=%b berr=%b rw=%b req_cycles=%0d stalls=%0d stall_wb=%b want 1/1/0/%0d/%0d/0",
               o.got, o.bus_error, o.wb_regwrite, o.nreq, o.stalls, o.stall_wb, TMO - 1, TMO);
    end
    // Response lands exactly on the last allowed cycle: completes normally.
    run_op(OP_LOAD, 3'b010, 32'h404, 32'h0, 5'd4, 2, TMO - 4, 0, 32'hCAFE_F00D, o);
    checks++;
    if ({o.got, o.bus_error, o.wb_value, o.wb_regwrite} !== {1'b1, 1'b0, 32'hCAFE_F00D, 1'b1}) begin
      failures++;
      $display("FAIL timeout_rsp_wins: got=%b berr=%b value=%h rw=%b want 1/0/cafef00d/1",
               o.got, o.bus_error, o.wb_value, o.wb_regwrite);
    end
    run_op(OP_STORE, 3'b010, 32'h408, 32'h1, 5'd4, 2, TMO - 3, 0, 32'h0, o);
    checks++;
    if ({o.got, o.bus_error, o.wb_regwrite, o.nreq} !== {1'b1, 1'b1, 1'b0, 32'd3}) begin
      failures++;
      $display("FAIL timeout_wait: got=%b berr=%b rw=%b reqs=%0d want 1/1/0/3",
               o.got, o.bus_error, o.wb_regwrite, o.nreq);
    end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    ex_valid = 1'b1; ex_opcode = OP_LOAD; ex_instruction = 32'h0000_2000;
    ex_alu_result = 32'h80; ex_rd = 5'd6; dmem_if.dmem_req_ready = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++;
    if ({dmem_if.dmem_req_valid, stall_out} !== 2'b01) begin
      failures++;
      $display("FAIL reach_wait: req_valid=%b stall=%b want 0/1", dmem_if.dmem_req_valid, stall_out);
    end
    #2 reset = 1'b0;
    ex_valid = 1'b0; dmem_if.dmem_req_ready = 1'b0;
    #1;
    checks++;
    if ({stall_out, dmem_if.dmem_req_valid, wb_valid, wb_regwrite, misaligned, bus_error,
         dmem_if.dmem_req_addr} !== '0) begin
      failures++;
      $display("FAIL async_reset_mid: stall=%b req_valid=%b wb_valid=%b addr=%h want all 0",
               stall_out, dmem_if.dmem_req_valid, wb_valid, dmem_if.dmem_req_addr);
    end
    @(posedge clock); @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    dmem_if.dmem_rsp_valid = 1'b1; dmem_if.dmem_rsp_rdata = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      dmem_if.dmem_rsp_valid = 1'b0;
      if (wb_valid || dmem_if.dmem_req_valid) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL late_rsp_ignored: %0d cycles with wb_valid/req_valid, want 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
